char_ram_arbiter: RTL
=====================

CHAR_RAM_ARBITER -- requirements
Module: char_ram_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 14, RAM address width; DATA_W, default 8, RAM data width; CLR_LAST, default 14'h3FFF, last address written by the clear engine.
REQ-002 clk  in  1  pixel clock; the only clock.
REQ-003 reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 vid_fetch  in  1  video read strobe, one cycle per cell fetch.
REQ-005 vid_addr  in  ADDR_W  video read address, {row,col}.
REQ-006 vid_data  out  DATA_W  captured video read data, held until the next capture.
REQ-007 vid_valid  out  1  one-cycle pulse when vid_data updates.
REQ-008 host_req, host_we  in  1 each  host request; 1=write, 0=read.
REQ-009 host_addr  in  ADDR_W; host_wdata  in  DATA_W  host address and write data.
REQ-010 host_ack  out  1  one-cycle pulse in the cycle the host access is issued to the RAM.
REQ-011 host_rdata  out  DATA_W; host_rvalid  out  1  read data, held; pulse when it updates.
REQ-012 clr_start  in  1; clr_value  in  DATA_W  clear-screen trigger and fill value.
REQ-013 clr_busy  out  1  high while the clear engine is active.
REQ-014 ram_addr  out  ADDR_W; ram_din  out  DATA_W; ram_we  out  1; ram_dout  in  DATA_W  single-port synchronous RAM port; dout reflects the address presented one cycle earlier.

Function
REQ-015 Priority per cycle SHALL be video > host > clear; exactly one requester owns the RAM port each cycle, and with no requester ram_we=0.
REQ-016 vid_fetch SHALL never be stalled: ram_addr=vid_addr, ram_we=0 in the same cycle (issue cycle N).
REQ-017 vid_data SHALL be registered from ram_dout at the end of cycle N+1; it is valid from N+2, with vid_valid=1 for exactly cycle N+2.
REQ-018 vid_fetch on consecutive cycles SHALL be legal; each fetch yields its own vid_valid pulse, in order.
REQ-019 Host side: host_req SHALL be held with stable addr/we/wdata until host_ack; host_ack is asserted combinationally in any cycle with host_req=1 and vid_fetch=0.
REQ-020 On an acked write, ram_we=1, ram_addr=host_addr, and ram_din=host_wdata in the ack cycle.
REQ-021 On an acked read in cycle N, host_rdata SHALL capture ram_dout at the end of N+1, and host_rvalid=1 in N+2.
REQ-022 Host_req sampled in the cycle after an ack SHALL be treated as a new request.
REQ-023 Clear engine states SHALL be IDLE and FILL.
- IDLE->FILL: on clr_start=1; latch clr_value; set counter to 0; clr_busy=1 from the next cycle.
- FILL: write the latched value at the counter address in each cycle neither video nor host owns the port, then increment the counter.
- FILL->IDLE: after the write at CLR_LAST; clr_busy=0 in the following cycle.
REQ-024 clr_start while in FILL SHALL be ignored; a changing clr_value while in FILL SHALL have no effect.
REQ-025 A write at an address SHALL be issued exactly once per clear; a cycle preempted by video or host SHALL not advance the counter.
REQ-026 Read/write ordering SHALL follow issue order: a host read issued after a write to the same address returns the new data.
REQ-027 Counter arithmetic SHALL be ADDR_W bits wide; the engine SHALL stop at CLR_LAST with no wrap past it.
REQ-028 No combinational path SHALL run from ram_dout to any output.

Reset
REQ-029 While reset_n=0 at a clk edge, the following SHALL be cleared:
- vid_data=0, vid_valid=0, host_rdata=0, host_rvalid=0;
- clr_busy=0, state=IDLE, counter=0;
- host_ack=0 and ram_we=0 for the reset cycle.
REQ-030 Reset during FILL SHALL abort the clear with no further writes; reset with a read in flight SHALL suppress its rvalid or vid_valid pulse.

Verification
REQ-031 Bench SHALL cover:
- Preload RAM[0x0021]=0x05; vid_fetch=1 with vid_addr=0x0021 at cycle N -> vid_valid at N+2 and vid_data=0x05, held until the next capture.
- host write 0x3C to 0x0100 with vid_fetch=1 in the same cycle -> host_ack delayed by one cycle; RAM[0x0100]=0x3C; video read unaffected.
- host read of 0x0100 immediately after that write -> host_rvalid two cycles after ack, host_rdata=0x3C.
- CLR_LAST=15, clr_start with clr_value=0x20, vid_fetch every 8th cycle, host idle -> addresses 0..15 = 0x20; clr_busy high for 16 plus the number of video-stolen cycles; second clr_start mid-fill ignored.
- reset_n=0 for one cycle during FILL at counter=5 -> clr_busy=0; addresses 6..15 unchanged; no spurious host_ack.

Source files
------------

// File: rtl/char_ram_arbiter.sv
// Character RAM arbiter: shares one single-port synchronous RAM between the
// video fetch path, a host read/write port and a clear-screen fill engine.
//
// Priority each cycle is video > host > clear. Video fetches are never
// stalled. Host requests are acknowledged in any cycle without a video fetch.
// The clear engine writes its latched fill value to addresses 0..CLR_LAST,
// one address per cycle that neither video nor host uses.
//
// Ports:
//   clk, reset_n              pixel clock, synchronous active-low reset
//   vid_fetch, vid_addr       video read strobe and address
//   vid_data, vid_valid       captured video data (held) and update pulse
//   host_req, host_we         host request, 1=write 0=read
//   host_addr, host_wdata     host address and write data
//   host_ack                  pulse in the cycle the host access is issued
//   host_rdata, host_rvalid   host read data (held) and update pulse
//   clr_start, clr_value      clear trigger and fill value
//   clr_busy                  high while the clear engine is filling
//   ram_addr, ram_din, ram_we RAM command port
//   ram_dout                  RAM read data, one cycle after the address
module char_ram_arbiter #(
  parameter int unsigned       ADDR_W   = 14,
  parameter int unsigned       DATA_W   = 8,
  parameter logic [ADDR_W-1:0] CLR_LAST = 14'h3FFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vid_fetch,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic {
    IDLE,
    FILL
  } clr_state_t;

  clr_state_t        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] clr_val;
  logic              clr_wr;
  logic              vid_pend;   // video read issued last cycle, data on ram_dout now
  logic              host_pend;  // host read issued last cycle, data on ram_dout now

  // Port mux. Reset gates every write and ack so nothing is issued in a
  // reset cycle.
  always_comb begin
    host_ack = reset_n & host_req & ~vid_fetch;
    clr_wr   = reset_n & (state == FILL) & ~vid_fetch & ~host_req;
    ram_addr = clr_cnt;
    ram_din  = clr_val;
    ram_we   = clr_wr;
    if (vid_fetch) begin
      ram_addr = vid_addr;
      ram_we   = 1'b0;
    end else if (host_req) begin
      ram_addr = host_addr;
      ram_din  = host_wdata;
      ram_we   = host_ack & host_we;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vid_pend    <= 1'b0;
      host_pend   <= 1'b0;
      vid_data    <= '0;
      vid_valid   <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
      state       <= IDLE;
      clr_busy    <= 1'b0;
      clr_cnt     <= '0;
      clr_val     <= '0;
    end else begin
      vid_pend    <= vid_fetch;
      host_pend   <= host_ack & ~host_we;
      vid_valid   <= vid_pend;
      host_rvalid <= host_pend;
      if (vid_pend) begin
        vid_data <= ram_dout;
      end
      if (host_pend) begin
        host_rdata <= ram_dout;
      end

      case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= FILL;
            clr_busy <= 1'b1;
            clr_cnt  <= '0;
            clr_val  <= clr_value;
          end
        end
        FILL: begin
          // Counter advances only on cycles the engine actually owns the port.
          if (clr_wr) begin
            if (clr_cnt == CLR_LAST) begin
              state    <= IDLE;
              clr_busy <= 1'b0;
            end else begin
              clr_cnt <= clr_cnt + ADDR_W'(1);
            end
          end
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
